d_latch_rst: RTL and testbench
==============================

D_LATCH_RST -- requirements
Module: d_latch_rst

Interface
Parameters: none; the block is a fixed single-bit cell.
REQ-001 clk  input  1  Latch enable; the block has one clock and clk is it; high = transparent, low = hold.
REQ-002 rst  input  1  Reset; asynchronous, active-high; clears the stored bit.
REQ-003 d  input  1  Data input.
REQ-004 q  output  1  Stored or transparent data value.
REQ-005 qb  output  1  Complement of q.
REQ-006 Port order SHALL be (d, clk, rst, q, qb) so positional instantiation in chained shift structures binds correctly.

Function
REQ-007 While rst=0 and clk=1, the latch SHALL be transparent: q follows d, including every d change during the high phase.
REQ-008 While rst=0 and clk=0, q SHALL hold the value present at the 1->0 transition of clk, independent of d.
REQ-009 On clk 1->0 with d changing in the same time step, the held value SHALL be d as sampled before the change (no setup margin is modelled).
REQ-010 qb SHALL equal ~q at all times, including during reset and hold, with no skew beyond a single delta step.
REQ-011 Level-sensitive behaviour is required: no edge-triggered flop; only a level-sensitive storage element is permitted.
REQ-012 No propagation delays SHALL be modelled; outputs update in zero simulated time (delta only).
REQ-013 Chaining several cells with a common clk SHALL make data ripple through all cells within one high phase; this is the intended behaviour, not a defect.
REQ-014 Implementation as behavioural always-block or cross-coupled gates is acceptable, provided it meets REQ-007 to REQ-012 and never produces q=qb.

Reset
REQ-015 rst=1 SHALL force q=0 and qb=1 immediately, regardless of clk and d.
REQ-016 rst SHALL dominate clk: with rst=1 and clk=1, q SHALL stay 0 whatever d does.
REQ-017 On rst 1->0 with clk=1, q SHALL take the current d in the same time step.
REQ-018 On rst 1->0 with clk=0, q SHALL remain 0 until the next high phase of clk.
REQ-019 Before the first reset or transparent phase, q and qb MAY be X; after either event they SHALL be known.

Verification
REQ-020 Transparency: rst=0, clk=1; d 0->1->0 at 5 ns steps -> q tracks d with each change, qb is always its complement.
REQ-021 Hold: clk=1, d=1; clk->0; then d toggles 0/1 for 100 ns -> q stays 1 and qb stays 0 throughout.
REQ-022 Async reset mid-hold: q=1, clk=0; rst pulse of 10 ns -> q=0 and qb=1 from the rst rising time; q=0 persists after rst falls until clk rises.
REQ-023 Reset dominance: clk=1, d=1, rst=1 for 100 ns -> q=0 throughout; rst->0 -> q=1 immediately.
REQ-024 Chain of 8 cells (q of cell i+1 drives d of cell i), clk period 50 ns, sin=1 from 25 ns -> every output is 1 by the end of the first clk high phase; rst=1 clears all 8 outputs to 0 with no clk edge.

Source files
------------

// File: rtl/d_latch_rst.sv
// ============================================================================
// d_latch_rst : level-sensitive D latch with asynchronous active-high reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module d_latch_rst (
   input  logic d,
   input  logic clk,
   input  logic rst,
   output logic q,
   output logic qb
);

   logic q_state;

   // Level-sensitive storage: clk high is transparent, clk low holds, rst wins.
   always_latch begin
      if (rst) begin
         q_state <= 1'b0;
      end else if (clk) begin
         q_state <= d;
      end
   end

   assign q  = q_state;
   assign qb = ~q_state;

endmodule

`default_nettype wire

// File: tb/tb_d_latch_rst.sv
// ============================================================================
// tb_d_latch_rst : self-checking bench for d_latch_rst and an 8-cell chain.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_d_latch_rst;

   logic d, clk, rst;
   logic q, qb;

   d_latch_rst dut (.d(d), .clk(clk), .rst(rst), .q(q), .qb(qb));

   // Chain: cell 7 takes sin, cell i takes q of cell i+1, link[0] is the far end.
   logic       cclk, crst, sin;
   wire  [8:0] link;
   wire  [7:0] chain_qb;
   assign link[8] = sin;

   generate
      for (genvar i = 0; i < 8; i++) begin : g_chain
         d_latch_rst u_cell (
            .d  (link[i+1]),
            .clk(cclk),
            .rst(crst),
            .q  (link[i]),
            .qb (chain_qb[i])
         );
      end
   endgenerate

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_q(input string name, input logic exp_q);
      check({name, ".q"},  {7'd0, q},  {7'd0, exp_q});
      check({name, ".qb"}, {7'd0, qb}, {7'd0, ~exp_q});
   endtask

   typedef struct {
      logic rst;
      logic clk;
      logic d;
      logic q;
   } vec_t;

   vec_t vt [13];

   logic model_q;
   logic r_rst, r_clk, r_d;

   initial begin
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};  // reset
      vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // reset dominates clk
      vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1};  // release while open -> d
      vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};  // close, hold 1
      vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};  // reset during hold
      vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0};  // release while closed stays 0
      vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1};
      vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1};  // close and change d same step
      vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1};

      d = 1'b0; clk = 1'b0; rst = 1'b1;
      cclk = 1'b0; crst = 1'b1; sin = 1'b0;
      #1;
      check_q("reset_state", 1'b0);

      // ---------------- table vectors ----------------
      for (int i = 0; i < 13; i++) begin
         clk = vt[i].clk;
         rst = vt[i].rst;
         d   = vt[i].d;
         #1;
         check_q($sformatf("vec%0d", i), vt[i].q);
         #4;
      end

      // ---------------- transparency ----------------
      rst = 1'b0; clk = 1'b1; d = 1'b0;
      #1 check_q("transp0", 1'b0);
      #4 d = 1'b1;
      #1 check_q("transp1", 1'b1);
      #4 d = 1'b0;
      #1 check_q("transp2", 1'b0);

      // ---------------- hold ----------------
      #4 d = 1'b1;
      #5 clk = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #4 d = ~d;
         #1 check_q("hold", 1'b1);
      end

      // ---------------- async reset mid-hold ----------------
      rst = 1'b1;
      #1 check_q("rst_hold_on", 1'b0);
      #9 rst = 1'b0;
      #1 check_q("rst_hold_off", 1'b0);
      d = 1'b1;
      #5 check_q("rst_hold_wait", 1'b0);
      clk = 1'b1;
      #1 check_q("rst_hold_open", 1'b1);

      // ---------------- reset dominance ----------------
      d = 1'b1; rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1 check_q("dominance", 1'b0);
         #8 d = ~d;
         #1;
      end
      d = 1'b1;
      #1 rst = 1'b0;
      #1 check_q("dominance_release", 1'b1);

      // ---------------- randomized vs model ----------------
      rst = 1'b1; clk = 1'b0; d = 1'b0;
      #1;
      model_q = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r_rst = ($urandom_range(0, 9) == 0);
         r_clk = 1'($urandom);
         r_d   = 1'($urandom);
         clk = r_clk;
         rst = r_rst;
         d   = r_d;
         if (r_rst)      model_q = 1'b0;
         else if (r_clk) model_q = r_d;
         #1 check_q("random", model_q);
         #2;
      end

      // ---------------- chain of 8 ----------------
      cclk = 1'b0; crst = 1'b1; sin = 1'b0;
      #5 crst = 1'b0;
      #19 check("chain_pre", link[7:0], 8'h00);
      #1 sin = 1'b1; cclk = 1'b1;
      #24 check("chain_ripple", link[7:0], 8'hFF);
      check("chain_ripple_qb", chain_qb, 8'h00);
      #1 cclk = 1'b0;
      #10 check("chain_hold", link[7:0], 8'hFF);
      crst = 1'b1;
      #1 check("chain_reset", link[7:0], 8'h00);
      check("chain_reset_qb", chain_qb, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
